dbus_sram_responder: RTL



---
 rtl/common_pkg.sv | 25 ++
 rtl/dbus_sram_responder_pkg.sv | 12 +
 rtl/dbus_sram_array.sv | 30 +++
 rtl/dbus_sram_responder.sv | 128 ++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared data-bus types used between the core (initiator) and its memory-side responders.
package common;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_pkg.sv
// Constants and FSM state type for the dbus SRAM responder.
package dbus_sram_responder_pkg;

  localparam int DBUS_WORD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/dbus_sram_array.sv
// DEPTH_WORDS x 64-bit storage: one registered read port, one byte-enable write port.
module dbus_sram_array
  import dbus_sram_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                         clk,
  input  logic [AW-1:0]                i_rd_idx,
  output logic [63:0]                  o_rd_data,
  input  logic                         i_we,
  input  logic [AW-1:0]                i_wr_idx,
  input  logic [DBUS_WORD_BYTES-1:0]   i_wr_strb,
  input  logic [63:0]                  i_wr_data
);

  logic [63:0] r_mem [DEPTH_WORDS];

  // NOTE: storage has no reset; contents survive rst, and a reset port would
  // stop this mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < DBUS_WORD_BYTES; i++) begin
        if (i_wr_strb[i]) r_mem[i_wr_idx][8*i +: 8] <= i_wr_data[8*i +: 8];
      end
    end
    o_rd_data <= r_mem[i_rd_idx];
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus slave with a fixed-latency SRAM model. Define DBUS_RESP_RAND_DELAY_EN to add
// an LFSR-driven 0-3 cycle extra delay per request for memory-stall testing.
module dbus_sram_responder
  import common::*;
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       rst,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = $clog2(LATENCY + 4);
  localparam logic [63:0] SPAN = 64'(DBUS_WORD_BYTES * DEPTH_WORDS);

  resp_state_t r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_next_cnt;
  logic [63:0]   r_addr, r_data;
  logic [7:0]    r_strobe;
  msize_t        r_size;

  logic          w_accept, w_we, w_lat_in_range;
  logic [1:0]    w_extra;
  logic [CW-1:0] w_total;
  logic [63:0]   w_req_off, w_lat_off, w_rd_data;
  logic [AW-1:0] w_rd_idx;

`ifdef DBUS_RESP_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_lfsr <= 16'hACE1;
    else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_extra = r_lfsr[1:0];
`else
  assign w_extra = 2'd0;
`endif

  assign w_accept       = (r_state == IDLE) && dreq.valid;
  assign w_total        = CW'(LATENCY) + CW'(w_extra);
  assign w_req_off      = dreq.addr - BASE_ADDR;
  assign w_lat_off      = r_addr - BASE_ADDR;
  assign w_lat_in_range = (r_addr >= BASE_ADDR) && (w_lat_off < SPAN);
  // The read port must see the incoming address on the accepting edge so LATENCY=1 works.
  assign w_rd_idx       = w_accept ? w_req_off[3 +: AW] : w_lat_off[3 +: AW];
  assign busy           = (r_state != IDLE);

  // Byte offset, high offset bits and size are not needed by the datapath.
  logic w_unused_bits;
  assign w_unused_bits = ^{r_size, w_req_off[2:0], w_req_off[63:AW+3],
                           w_lat_off[2:0], w_lat_off[63:AW+3]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_strobe <= '0;
      r_size   <= MSIZE1;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_accept) begin
        r_addr   <= dreq.addr;
        r_data   <= dreq.data;
        r_strobe <= dreq.strobe;
        r_size   <= dreq.size;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    dresp        = '0;
    w_we         = 1'b0;
    case (r_state)
      IDLE: begin
        if (dreq.valid) begin
          if (w_total == CW'(1)) begin
            w_next_state = RESP;
          end else begin
            w_next_state = WAIT;
            w_next_cnt   = w_total - CW'(1);
          end
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == CW'(1)) begin
          w_next_state = RESP;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt - CW'(1);
        end
      end
      RESP: begin
        w_next_state  = IDLE;
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        if (r_strobe == 8'h00) dresp.data = w_lat_in_range ? w_rd_data : 64'h0;
        else                   w_we       = w_lat_in_range;
      end
      default: w_next_state = IDLE;
    endcase
  end

  dbus_sram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk       (clk),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .i_we      (w_we),
    .i_wr_idx  (w_lat_off[3 +: AW]),
    .i_wr_strb (r_strobe),
    .i_wr_data (r_data)
  );

endmodule
